// File: rtl/csa_pkg.sv
// ----------------------------------------------------------------------------
// csa_pkg : shared types and helpers for the pipelined carry-select adder.
//   CSA_WIDTH / CSA_BLOCK : default operand width and segment width.
//   csa_seg_t             : dual-result of one segment (carry-in 0 and 1).
//   nblk()                : number of select segments for a given width.
// ----------------------------------------------------------------------------
package csa_pkg;

   localparam int CSA_WIDTH = 32;
   localparam int CSA_BLOCK = 8;

   // Both speculative results of one segment; the real carry-in picks one.
   typedef struct packed {
      logic [CSA_BLOCK-1:0] s0;
      logic [CSA_BLOCK-1:0] s1;
      logic                 c0;
      logic                 c1;
   } csa_seg_t;

   function automatic int nblk(input int width, input int block);
      return width / block;
   endfunction

endpackage

// File: rtl/csa_seg.sv
// ----------------------------------------------------------------------------
// csa_seg : combinational CSA_BLOCK-bit dual ripple adder.
//   a_i, b_i : segment operand bits
//   seg_o    : {s0,c0} = a+b, {s1,c1} = a+b+1
// ----------------------------------------------------------------------------
module csa_seg
   import csa_pkg::*;
(
   input  logic [CSA_BLOCK-1:0] a_i,
   input  logic [CSA_BLOCK-1:0] b_i,
   output csa_seg_t             seg_o
);

   // Two independent ripple chains, one per assumed carry-in.
   always_comb begin
      logic k0;
      logic k1;
      logic p;
      logic g;
      seg_o = '0;
      k0    = 1'b0;
      k1    = 1'b1;
      for (int i = 0; i < CSA_BLOCK; i++) begin
         p = a_i[i] ^ b_i[i];
         g = a_i[i] & b_i[i];
         seg_o.s0[i] = p ^ k0;
         seg_o.s1[i] = p ^ k1;
         k0 = g | (p & k0);
         k1 = g | (p & k1);
      end
      seg_o.c0 = k0;
      seg_o.c1 = k1;
   end

endmodule

// File: rtl/csa_pipe.sv
// ----------------------------------------------------------------------------
// csa_pipe : pipelined carry-select adder, {cout,sum} = a + b + cin.
//   Operands are cut into BLOCK-bit segments; each pipeline stage resolves BPS
//   segments and carries the not-yet-added upper operand bits forward (skew).
//   Elastic valid/ready on both sides, one result per cycle sustained.
//
//   clk, rst_n          : clock (rising), async active-low reset
//   in_valid/in_ready   : operand handshake; a, b, cin sampled on handshake
//   out_valid/out_ready : result handshake; sum, cout, ovf held while stalled
//   ovf                 : signed overflow, only when CSA_PIPE_OVF_EN is
//                         defined (tied 0 otherwise)
//
//   Latency is NSTG = WIDTH/BLOCK/BPS cycles. BLOCK must equal CSA_BLOCK since
//   the segment struct width is fixed in the package.
// ----------------------------------------------------------------------------
module csa_pipe
   import csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH,
   parameter int BLOCK = CSA_BLOCK,
   parameter int BPS   = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NBLK = nblk(WIDTH, BLOCK);
   localparam int NSTG = NBLK / BPS;
   localparam int SW   = BPS * BLOCK;   // bits resolved per stage

   if (WIDTH % BLOCK != 0) begin : g_chk_width
      $error("csa_pipe: WIDTH %0d is not a multiple of BLOCK %0d", WIDTH, BLOCK);
   end
   if (NBLK % BPS != 0) begin : g_chk_bps
      $error("csa_pipe: NBLK %0d is not a multiple of BPS %0d", NBLK, BPS);
   end
   if (BLOCK != CSA_BLOCK) begin : g_chk_block
      $error("csa_pipe: BLOCK %0d must equal CSA_BLOCK %0d", BLOCK, CSA_BLOCK);
   end

   // ------------------------------------------------------------------
   // Valid/ready control
   // ------------------------------------------------------------------
   logic [NSTG-1:0] vld_q;
   logic [NSTG-1:0] vin;   // valid presented to each stage
   logic [NSTG-1:0] en;    // stage may load: empty, or its content moves on
   logic [NSTG-1:0] ld;    // stage captures a real beat

   if (NSTG > 1) begin : g_vin
      assign vin = {vld_q[NSTG-2:0], in_valid};
   end else begin : g_vin
      assign vin = in_valid;
   end

   // Ready propagates backwards from the output; a full pipe still accepts
   // when everything shifts in the same cycle.
   always_comb begin
      en = '0;
      en[NSTG-1] = !vld_q[NSTG-1] || out_ready;
      for (int j = NSTG - 2; j >= 0; j--) begin
         en[j] = !vld_q[j] || en[j+1];
      end
   end

   assign ld       = en & vin;
   assign in_ready = en[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= (vld_q & ~en) | (vin & en);
   end

   // ------------------------------------------------------------------
   // Datapath stages
   // ------------------------------------------------------------------
   for (genvar j = 0; j < NSTG; j++) begin : g_stg
      localparam int LO = j * SW;    // first bit resolved in this stage
      localparam int HI = LO + SW;   // bits resolved once this stage is done

      logic [WIDTH-LO-1:0] a_in;     // operand bits not yet added
      logic [WIDTH-LO-1:0] b_in;
      logic                c_in;
      csa_seg_t            seg [BPS];
      logic [SW-1:0]       rs;
      logic                c_d;
      logic [HI-1:0]       sum_d;
      logic [HI-1:0]       sum_q;
      logic                c_q;

      if (j == 0) begin : g_src
         assign a_in  = a;
         assign b_in  = b;
         assign c_in  = cin;
         assign sum_d = rs;
      end else begin : g_src
         assign a_in  = g_stg[j-1].g_skew.a_q;
         assign b_in  = g_stg[j-1].g_skew.b_q;
         assign c_in  = g_stg[j-1].c_q;
         assign sum_d = {rs, g_stg[j-1].sum_q};
      end

      for (genvar k = 0; k < BPS; k++) begin : g_seg
         csa_seg u_seg (
            .a_i   (a_in[k*BLOCK +: BLOCK]),
            .b_i   (b_in[k*BLOCK +: BLOCK]),
            .seg_o (seg[k])
         );
      end

      // Select chain: the carry entering each segment picks its result.
      always_comb begin
         logic c;
         c  = c_in;
         rs = '0;
         for (int k = 0; k < BPS; k++) begin
            rs[k*BLOCK +: BLOCK] = c ? seg[k].s1 : seg[k].s0;
            c = c ? seg[k].c1 : seg[k].c0;
         end
         c_d = c;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q <= '0;
            c_q   <= 1'b0;
         end else if (ld[j]) begin
            sum_q <= sum_d;
            c_q   <= c_d;
         end
      end

      // Upper operand bits still to be added downstream. The operand sign
      // bits ride along here naturally until the last stage consumes them.
      if (j < NSTG - 1) begin : g_skew
         logic [WIDTH-HI-1:0] a_q;
         logic [WIDTH-HI-1:0] b_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (ld[j]) begin
               a_q <= a_in[WIDTH-LO-1:SW];
               b_q <= b_in[WIDTH-LO-1:SW];
            end
         end
      end

`ifdef CSA_PIPE_OVF_EN
      if (j == NSTG - 1) begin : g_ovf
         logic ovf_d;
         logic ovf_q;
         assign ovf_d = (a_in[SW-1] == b_in[SW-1]) && (rs[SW-1] != a_in[SW-1]);
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      ovf_q <= 1'b0;
            else if (ld[j])  ovf_q <= ovf_d;
         end
      end
`endif
   end

   assign out_valid = vld_q[NSTG-1];
   assign sum       = g_stg[NSTG-1].sum_q;
   assign cout      = g_stg[NSTG-1].c_q;
`ifdef CSA_PIPE_OVF_EN
   assign ovf       = g_stg[NSTG-1].g_ovf.ovf_q;
`else
   assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// ----------------------------------------------------------------------------
// tb_csa_pipe : two adders (BPS=1 -> 4 stages, BPS=2 -> 2 stages) share one
// stimulus stream. Each has a queue scoreboard fed on accept and checked on
// every valid output cycle against plain a+b+cin arithmetic.
// ----------------------------------------------------------------------------
module tb_csa_pipe;

   localparam int W = 32;
`ifdef CSA_PIPE_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              in_valid  = 1'b0;
   logic              cin       = 1'b0;
   logic              out_ready = 1'b0;
   logic [W-1:0]      a         = '0;
   logic [W-1:0]      b         = '0;
   logic [1:0]        in_ready;
   logic [1:0]        out_valid;
   logic [1:0]        cout;
   logic [1:0]        ovf;
   logic [1:0][W-1:0] sum;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   csa_pipe #(.WIDTH(W), .BLOCK(8), .BPS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid[0]), .out_ready(out_ready),
      .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0])
   );

   csa_pipe #(.WIDTH(W), .BLOCK(8), .BPS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid[1]), .out_ready(out_ready),
      .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1])
   );

   // {ovf, cout, sum}
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
      logic [W:0] r;
      logic       o;
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      o = OVF_ON && (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      return {o, r};
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboards, sampled on the falling edge.
   for (genvar g = 0; g < 2; g++) begin : g_sb
      logic [W+1:0] q[$];
      int           qsz = 0;
      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
         end else begin
            if (out_valid[g]) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb%0d_spurious: got sum=%0h with no beat pending", g, sum[g]);
               end else begin
                  chk($sformatf("sb%0d_result", g), {ovf[g], cout[g], sum[g]}, q[0]);
                  if (out_ready) void'(q.pop_front());
               end
            end
            if (in_valid && in_ready[g]) q.push_back(model(a, b, cin));
         end
         qsz = q.size();
      end
   end

   task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          output int lat);
      @(posedge clk); #1;
      in_valid = 1'b1; a = x; b = y; cin = c; out_ready = 1'b1;
      @(negedge clk);
      chk("one_in_ready", in_ready[0], 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid[0] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int nacc;
      int nov;
      int first;
      int last;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum0", sum[0], 0);
      chk("rst_sum1", sum[1], 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 2'b11);

      // 1: wrap to zero with carry-out
      run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
      chk("t1_latency", lat, 4);
      chk("t1_sum", sum[0], 32'h0000_0000);
      chk("t1_cout", cout[0], 1);
      chk("t1_ovf", ovf[0], 0);
      repeat (6) @(posedge clk);

      // 2: signed overflow
      run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
      chk("t2_latency", lat, 4);
      chk("t2_sum", sum[0], 32'h8000_0000);
      chk("t2_cout", cout[0], 0);
      chk("t2_ovf", ovf[0], OVF_ON);
      repeat (6) @(posedge clk);

      // 3: 8 back-to-back beats
      nov = 0; first = -1; last = -1;
      for (int n = 0; n < 24; n++) begin
         @(posedge clk); #1;
         in_valid  = (n < 8);
         a         = 32'(n);
         b         = 32'(n) << 24;
         cin       = n[0];
         out_ready = 1'b1;
         @(negedge clk);
         if (n < 8) chk($sformatf("t3_in_ready_%0d", n), in_ready[0], 1);
         if (out_valid[0]) begin
            nov++;
            if (first < 0) first = n;
            last = n;
         end
      end
      chk("t3_count", nov, 8);
      chk("t3_first", first, 4);
      chk("t3_consecutive", last - first, 7);

      // 4: backpressure, fill, then drain and resume
      nacc = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; out_ready = 1'b0;
         a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_ready[0]) nacc++;
      end
      chk("t4_accepts", nacc, 4);
      chk("t4_stalled", in_ready, 2'b00);
      chk("t4_out_valid", out_valid, 2'b11);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t4_resume_ready", in_ready[0], 1);
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk($sformatf("t4_stream_ready_%0d", n), in_ready[0], 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("t4_q0_empty", g_sb[0].qsz, 0);
      chk("t4_q1_empty", g_sb[1].qsz, 0);

      // 5: reset with 3 beats in flight
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; out_ready = 1'b1;
         a = $urandom | 32'h1; b = $urandom; cin = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_sum0", sum[0], 0);
      chk("t5_sum1", sum[1], 0);
      chk("t5_cout", cout, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      nov = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (out_valid != 2'b00) nov++;
      end
      chk("t5_no_stale", nov, 0);

      // 6: random traffic with random backpressure
      nacc = 0;
      for (int n = 0; n < 6000 && nacc < 1000; n++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = pick();
         b         = pick();
         cin       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready[0]) nacc++;
      end
      chk("t6_accepted", (nacc >= 1000), 1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) @(negedge clk);
      chk("t6_q0_empty", g_sb[0].qsz, 0);
      chk("t6_q1_empty", g_sb[1].qsz, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
